// File: rtl/ex_mem_mul_stage.sv
// EX/MEM pipeline register with ALU/MUL result select.
// The multiplier is a MUL_LAT-cycle multicycle path; EX is held until it settles.
module ex_mem_mul_stage #(
  parameter int XLEN    = 32,
  parameter int MUL_LAT = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ex_valid,
  input  logic            ex_is_mul,
  input  logic [XLEN-1:0] ex_alu_out,
  input  logic [XLEN-1:0] mul_out,
  input  logic [4:0]      ex_rd,
  input  logic            ex_reg_write,
  input  logic            ex_mem_read,
  input  logic            ex_mem_write,
  input  logic [2:0]      ex_funct3,
  input  logic [XLEN-1:0] ex_rs2_data,
  input  logic            mem_stall,
  input  logic            flush,
  output logic            ex_stall,
  output logic            mem_valid,
  output logic [XLEN-1:0] mem_result,
  output logic [4:0]      mem_rd,
  output logic            mem_reg_write,
  output logic            mem_mem_read,
  output logic            mem_mem_write,
  output logic [2:0]      mem_funct3,
  output logic [XLEN-1:0] mem_store_data
);

  typedef enum logic {
    IDLE,
    MUL_WAIT
  } state_t;

  localparam logic       MULTI    = (MUL_LAT > 1);
  localparam logic [2:0] CNT_INIT = 3'((MUL_LAT > 1) ? MUL_LAT - 2 : 0);

  state_t          state;
  logic [2:0]      cnt;
  logic            mul_start;
  logic            mul_wait_active;
  logic            capture_ok;
  logic [XLEN-1:0] sel_result;

  assign mul_start  = ex_valid & ex_is_mul & MULTI;
  assign mul_wait_active = ((state == IDLE) & mul_start)
                         | ((state == MUL_WAIT) & (cnt != 3'd0));
  assign ex_stall   = mem_stall | (mul_wait_active & ~flush);
  assign capture_ok = ~mem_stall & ~ex_stall & ~flush;
  assign sel_result = ex_is_mul ? mul_out : ex_alu_out;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= 3'd0;
    end else begin
      case (state)
        IDLE: begin
          if (mul_start & ~flush & ~mem_stall) begin
            state <= MUL_WAIT;
            cnt   <= CNT_INIT;
          end
        end
        MUL_WAIT: begin
          if (flush) begin
            state <= IDLE;
            cnt   <= 3'd0;
          end else if (!mem_stall) begin
            if (cnt == 3'd0) state <= IDLE;
            else             cnt   <= cnt - 3'd1;
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= 3'd0;
        end
      endcase
    end
  end

  // data fields keep their old values across bubbles
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_valid      <= 1'b0;
      mem_result     <= '0;
      mem_rd         <= '0;
      mem_reg_write  <= 1'b0;
      mem_mem_read   <= 1'b0;
      mem_mem_write  <= 1'b0;
      mem_funct3     <= '0;
      mem_store_data <= '0;
    end else if (!mem_stall) begin
      if (ex_valid & capture_ok) begin
        mem_valid      <= 1'b1;
        mem_result     <= sel_result;
        mem_rd         <= ex_rd;
        mem_reg_write  <= ex_reg_write;
        mem_mem_read   <= ex_mem_read;
        mem_mem_write  <= ex_mem_write;
        mem_funct3     <= ex_funct3;
        mem_store_data <= ex_rs2_data;
      end else begin
        mem_valid      <= 1'b0;
        mem_reg_write  <= 1'b0;
        mem_mem_read   <= 1'b0;
        mem_mem_write  <= 1'b0;
      end
    end
  end

endmodule
